imem_loader: RTL and testbench

Boot-time program loader that writes the processor's instruction memory from a byte stream. It accepts a framed stream (length, payload, checksum) over a valid/ready handshake and assembles little-endian 32-bit words. It issues one write per word to the instruction memory's write port and holds the processor core in reset until a frame loads cleanly. It sits beside the core at top level and drives the core's reset input.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed byte stream (length, payload, checksum),
// writes little-endian 32-bit words into instruction memory and releases the
// core from reset once a frame has loaded cleanly.
module imem_loader #(
  parameter int unsigned noal = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int unsigned LEN_W  = 16;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(noal);

  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
  } state_t;

  state_t           state_q, state_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] word_idx_q, word_idx_n;
  logic [1:0]       byte_cnt_q, byte_cnt_n;
  logic [7:0]       xor_q, xor_n;
  logic [23:0]      buf_q, buf_n;
  logic             we_n;
  logic [31:0]      waddr_n, wdata_n;
  logic             cpu_reset_n, done_n, error_n;
  logic             accept;
  logic [LEN_W-1:0] len_full;

  // Ready whenever the frame parser is active; never during reset
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                 (state_q == DATA)   || (state_q == CSUM);
    end
  end

  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_q[7:0]};

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    len_n      = len_q;
    word_idx_n = word_idx_q;
    byte_cnt_n = byte_cnt_q;
    xor_n      = xor_q;
    buf_n      = buf_q;
    we_n       = 1'b0;
    waddr_n    = imem_waddr;
    wdata_n    = imem_wdata;

    case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_n[7:0] = in_data;
          state_n    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_n = len_full;
          if (len_full > LEN_MAX) begin
            state_n = ERR;
          end else if (len_full == '0) begin
            state_n = CSUM;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          xor_n      = xor_q ^ in_data;
          byte_cnt_n = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: buf_n[7:0]   = in_data;
            2'd1: buf_n[15:8]  = in_data;
            2'd2: buf_n[23:16] = in_data;
            default: begin
              we_n    = 1'b1;
              wdata_n = {in_data, buf_q};
              waddr_n = 32'({word_idx_q, 2'b00});
              if (word_idx_q == len_q - LEN_W'(1)) begin
                state_n = CSUM;
              end else begin
                word_idx_n = word_idx_q + LEN_W'(1);
              end
            end
          endcase
        end
      end
      CSUM: begin
        if (accept) begin
          state_n = (in_data == xor_q) ? DONE : ERR;
        end
      end
      DONE, ERR: begin
        if (load_req) begin
          state_n    = LEN_LO;
          len_n      = '0;
          word_idx_n = '0;
          byte_cnt_n = '0;
          xor_n      = '0;
        end
      end
      default: state_n = LEN_LO;
    endcase

    cpu_reset_n = (state_n != DONE);
    done_n      = (state_n == DONE);
    error_n     = (state_n == ERR);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LEN_LO;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      xor_q      <= '0;
      buf_q      <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_n;
      len_q      <= len_n;
      word_idx_q <= word_idx_n;
      byte_cnt_q <= byte_cnt_n;
      xor_q      <= xor_n;
      buf_q      <= buf_n;
      imem_we    <= we_n;
      imem_waddr <= waddr_n;
      imem_wdata <= wdata_n;
      cpu_reset  <= cpu_reset_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes go into a
// scoreboard queue as the stimulus is driven and are checked by a monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_req;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] pl[$];

  imem_loader #(.noal(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write monitor: every imem_we pulse must match the head of the scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h, no write expected", imem_waddr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_waddr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   imem_waddr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pl_xor();
    logic [7:0] x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  // Present one byte (after an optional idle gap) and wait for its accept
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout byte=%h in_ready=%b expected accept", b, in_ready);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Send a complete frame from pl; writes are pushed as each word's last byte is driven
  task automatic send_frame(input logic [15:0] cnt, input logic [7:0] csum, input int max_gap);
    send_byte(cnt[7:0], 0);
    send_byte(cnt[15:8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    for (int i = 0; i < int'(cnt) * 4; i++) begin
      if (i % 4 == 3) begin
        exp_q.push_back('{addr: 32'(4 * (i / 4)),
                          data: {pl[i], pl[i-1], pl[i-2], pl[i-3]}});
      end
      send_byte(pl[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    send_byte(csum, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    idle();
    @(negedge clk);
  endtask

  task automatic check_done(input string name);
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s done/cpu_reset/error got %b%b%b expected 100", name, done, cpu_reset, error);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_writes got %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_err(input string name);
    checks++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s error/cpu_reset/done/in_ready got %b%b%b%b expected 1100",
               name, error, cpu_reset, done, in_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_writes got %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic load_two_word();
    pl = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; load_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || imem_waddr !== 32'h0 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_port got we=%b addr=%h data=%h expected 0/0/0", imem_we, imem_waddr, imem_wdata);
    end
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status cpu_reset/done/error/in_ready got %b%b%b%b expected 1000",
               cpu_reset, done, error, in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_good_frame();
    load_two_word();
    send_frame(16'd2, pl_xor(), 0);
    check_done("good_frame");
  endtask

  task automatic test_bad_csum();
    pulse_load_req();
    load_two_word();
    send_frame(16'd2, 8'h00, 0);
    check_err("bad_csum");
  endtask

  task automatic test_too_long();
    pulse_load_req();
    send_byte(8'h09, 0);
    send_byte(8'h00, 0);
    idle();
    repeat (4) @(negedge clk);
    check_err("too_long");
  endtask

  task automatic test_zero_len();
    pulse_load_req();
    pl.delete();
    send_frame(16'd0, 8'h00, 0);
    check_done("zero_len");
    pulse_load_req();
    send_frame(16'd0, 8'h5A, 0);
    check_err("zero_len_bad_csum");
  endtask

  task automatic test_gaps_and_hold();
    pulse_load_req();
    load_two_word();
    send_frame(16'd2, pl_xor(), 3);
    check_done("gap_frame");
    // Hold a byte while DONE: it must not be consumed
    in_data  = 8'h02;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_in_done done/in_ready got %b%b expected 10", done, in_ready);
    end
    pulse_load_req();
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload cpu_reset/done/in_ready got %b%b%b expected 101", cpu_reset, done, in_ready);
    end
    send_frame(16'd2, pl_xor(), 0);
    check_done("held_byte_frame");
  endtask

  task automatic test_load_req_ignored();
    pulse_load_req();
    pl = '{8'hB7, 8'h02, 8'h00, 8'h80};
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    idle();
    pulse_load_req();
    exp_q.push_back('{addr: 32'h0, data: 32'h800002B7});
    for (int i = 0; i < 4; i++) send_byte(pl[i], 0);
    send_byte(pl_xor(), 0);
    idle();
    @(negedge clk);
    check_done("load_req_ignored");
  endtask

  task automatic test_reset_mid_frame();
    pulse_load_req();
    pl.delete();
    for (int i = 0; i < 12; i++) pl.push_back(8'(8'h40 + i));
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) exp_q.push_back('{addr: 32'h0, data: {pl[3], pl[2], pl[1], pl[0]}});
      send_byte(pl[i], 0);
    end
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset in_ready/cpu_reset/done/error got %b%b%b%b expected 1100",
               in_ready, cpu_reset, done, error);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset pending_writes got %0d expected 0", exp_q.size());
    end
    pl = '{8'h37, 8'h11, 8'h22, 8'h33};
    send_frame(16'd1, pl_xor(), 0);
    check_done("fresh_frame");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_too_long();
    test_zero_len();
    test_gaps_and_hold();
    test_load_req_ignored();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
